// File: rtl/wts_pkg.sv
// Shared definitions for the wavetable SRAM arbiter slice.
// Holds the slot count, the SCCI bank code, the address/data widths, the
// captured CPU request record and small helpers for slot stepping and
// tone-generator address formation.
// Optional feature macro used by the arbiter: WTS_CPU_PRIORITY_EN.
package wts_pkg;

  localparam int NUM_SLOTS = 6;
  localparam int SLOT_W    = 3;
  localparam int CPU_ID_W  = 3;
  localparam int CPU_A_W   = 7;
  localparam int WAVE_A_W  = 7;
  localparam int SRAM_A_W  = 10;
  localparam int DATA_W    = 8;

  // Bank code substituted for slots 4/5 when the SCCI mode is off.
  localparam logic [SLOT_W-1:0] SCCI_BANK = 3'b011;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  typedef struct packed {
    logic [CPU_ID_W-1:0] id;
    logic [CPU_A_W-1:0]  a;
    logic [DATA_W-1:0]   d;
    logic                we;
    bank_e               bank;
  } cpu_req_t;

  // Slot after 'slot' in the 0..NUM_SLOTS-1 ring.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot);
    return (slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot + SLOT_W'(1);
  endfunction

  // Tone-generator address: slots 4/5 fold onto the SCCI bank unless the
  // SCCI mode is enabled, in which case the slot index is used directly.
  function automatic logic [SRAM_A_W-1:0] tone_addr(input logic [SLOT_W-1:0]   slot,
                                                    input logic [WAVE_A_W-1:0] wave,
                                                    input logic                scci_en);
    return (slot[SLOT_W-1] && !scci_en) ? {SCCI_BANK, wave} : {slot, wave};
  endfunction

endpackage

// File: rtl/wts_sram_arbiter_if.sv
// CPU request bus of the wavetable SRAM arbiter.
// master: CPU side, drives cpu_req/cpu_we/cpu_bank/cpu_id/cpu_a/cpu_d
//         (level-held until cpu_ack) and receives cpu_ack/cpu_q/cpu_q_valid.
// slave : arbiter side, the mirror image.
interface wts_sram_arbiter_if;
  import wts_pkg::*;

  logic                cpu_req;
  logic                cpu_we;
  logic                cpu_bank;
  logic [CPU_ID_W-1:0] cpu_id;
  logic [CPU_A_W-1:0]  cpu_a;
  logic [DATA_W-1:0]   cpu_d;
  logic                cpu_ack;
  logic [DATA_W-1:0]   cpu_q;
  logic                cpu_q_valid;

  modport master (
    output cpu_req, cpu_we, cpu_bank, cpu_id, cpu_a, cpu_d,
    input  cpu_ack, cpu_q, cpu_q_valid
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_bank, cpu_id, cpu_a, cpu_d,
    output cpu_ack, cpu_q, cpu_q_valid
  );

endinterface

// File: rtl/wts_slot_sequencer.sv
// Six-slot sequencer for the wavetable SRAM arbiter.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   hold         - when high, the slot index does not advance on this edge
//   active       - current slot index 0..5
//   frame_start  - high in slot 0 unless that cycle is a held (stall) cycle
module wts_slot_sequencer
  import wts_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  output logic [SLOT_W-1:0] active,
  output logic              frame_start
);

  logic [SLOT_W-1:0] active_q, active_d;
  logic              held_q, held_d;

  // Advance unless held; held_q marks the repeated (stall) cycle that follows
  // a hold so that slot 0 is only announced once per frame.
  always_comb begin
    active_d = hold ? active_q : next_slot(active_q);
    held_d   = hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      held_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      held_q   <= held_d;
    end
  end

  assign active      = active_q;
  assign frame_start = (active_q == '0) && !held_q && !reset;

endmodule

// File: rtl/wts_sram_arbiter.sv
// Wavetable SRAM arbiter: shares two 1-clock-latency SRAM banks between the
// tone generator (slot-indexed addressing) and single CPU accesses.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   cpu (slave modport)     - CPU request/ack/read-data bus
//   wave_address0/1         - tone-generator addresses per bank
//   reg_scci_enable         - SCCI mode, disables folding slots 4/5 onto bank 3
//   active, frame_start     - slot index and frame marker
//   stall                   - CPU access cycle, downstream holds
//   sram_a0/a1, sram_we0/1, sram_d, sram_q0/1 - SRAM bank ports
// Macro WTS_CPU_PRIORITY_EN: when defined, a captured request is served in
// the very next cycle, inserting a stall cycle; otherwise requests wait for
// slot 0 and stall stays low.
module wts_sram_arbiter
  import wts_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  wts_sram_arbiter_if.slave   cpu,
  input  logic [WAVE_A_W-1:0] wave_address0,
  input  logic [WAVE_A_W-1:0] wave_address1,
  input  logic                reg_scci_enable,
  output logic [SLOT_W-1:0]   active,
  output logic                frame_start,
  output logic                stall,
  output logic [SRAM_A_W-1:0] sram_a0,
  output logic [SRAM_A_W-1:0] sram_a1,
  output logic                sram_we0,
  output logic                sram_we1,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q0,
  input  logic [DATA_W-1:0]   sram_q1
);

  cpu_req_t          req_q, req_d;
  logic              pending_q, pending_d;
  logic              block_q, block_d;
  logic              rd_pend_q, rd_pend_d;
  bank_e             rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] q_hold_q, q_hold_d;
  logic [DATA_W-1:0] rd_data;
  logic              capture;
  logic              service;
  logic              hold;

`ifndef WTS_CPU_PRIORITY_EN
  logic ready_q, ready_d;
`endif

  // A request is taken only into an empty buffer, and only after cpu_req has
  // been seen low since the previous ack (block_q), so a CPU that keeps
  // cpu_req high after its ack is not served twice.
  always_comb begin
    capture = cpu.cpu_req && !pending_q && !block_q;
`ifdef WTS_CPU_PRIORITY_EN
    service = pending_q && !reset;
    hold    = capture;
`else
    service = pending_q && ready_q && (active == '0) && !reset;
    hold    = 1'b0;
`endif
  end

  wts_slot_sequencer u_seq (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .active      (active),
    .frame_start (frame_start)
  );

  assign rd_data = (rd_bank_q == BANK1) ? sram_q1 : sram_q0;

  // Request buffer, edge qualifier and read-return bookkeeping.
  always_comb begin
    req_d     = req_q;
    pending_d = pending_q;
    block_d   = block_q;
    rd_pend_d = 1'b0;
    rd_bank_d = rd_bank_q;
    q_hold_d  = q_hold_q;
    if (capture) begin
      req_d     = '{id: cpu.cpu_id, a: cpu.cpu_a, d: cpu.cpu_d,
                    we: cpu.cpu_we, bank: bank_e'(cpu.cpu_bank)};
      pending_d = 1'b1;
    end
    if (service) begin
      pending_d = 1'b0;
      block_d   = 1'b1;
      if (!req_q.we) begin
        rd_pend_d = 1'b1;
        rd_bank_d = req_q.bank;
      end
    end else if (!cpu.cpu_req) begin
      block_d = 1'b0;
    end
    if (rd_pend_q) begin
      q_hold_d = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      pending_q <= 1'b0;
      block_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_bank_q <= BANK0;
      q_hold_q  <= '0;
    end else begin
      req_q     <= req_d;
      pending_q <= pending_d;
      block_q   <= block_d;
      rd_pend_q <= rd_pend_d;
      rd_bank_q <= rd_bank_d;
      q_hold_q  <= q_hold_d;
    end
  end

`ifndef WTS_CPU_PRIORITY_EN
  // A request only becomes eligible after one full cycle in the buffer, so a
  // capture on the edge that enters slot 0 waits for the next frame.
  always_comb begin
    ready_d = pending_q && !service;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end
`endif

`ifdef WTS_CPU_PRIORITY_EN
  assign stall = pending_q;
`else
  assign stall = 1'b0;
`endif

  // SRAM address/write mux: the CPU owns both banks in its service cycle,
  // the tone generator owns them otherwise.
  always_comb begin
    sram_a0  = tone_addr(active, wave_address0, reg_scci_enable);
    sram_a1  = tone_addr(active, wave_address1, reg_scci_enable);
    sram_we0 = 1'b0;
    sram_we1 = 1'b0;
    sram_d   = req_q.d;
    if (service) begin
      sram_a0  = {req_q.id, req_q.a};
      sram_a1  = {req_q.id, req_q.a};
      sram_we0 = req_q.we && (req_q.bank == BANK0);
      sram_we1 = req_q.we && (req_q.bank == BANK1);
    end
  end

  // Read data is forwarded straight from the bank in the return cycle and
  // then held until the next read completes.
  assign cpu.cpu_ack     = service;
  assign cpu.cpu_q_valid = rd_pend_q;
  assign cpu.cpu_q       = rd_pend_q ? rd_data : q_hold_q;

endmodule
